tlb_lookup_unit: RTL and testbench

TLB_LOOKUP_UNIT -- requirements
Module: TlbLookupUnit

---
 rtl/tlb_lookup_unit.sv | 167 ++++++++++++++++
 tb/tb_tlb_lookup_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_unit.sv
// Fully associative TLB with a combinational lookup and a miss FSM that drives a page-table replacer.
// Optional invalidate port and its logic are compiled in with `define TLB_FLUSH_EN.
module tlb_lookup_unit #(
    parameter int EntryCount = 8,
    parameter int PageW      = 20,
    parameter int FlagsW     = 8,
    parameter int AccessW    = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        requestValid_i,
    input  logic [PageW-1:0]            requestPage_i,
    input  logic [AccessW-1:0]          requestAccessType_i,
    output logic                        done_o,
    // Entry layout: {valid, fault, pageNumber[PageW], flags[FlagsW]}
    output logic [PageW+FlagsW+1:0]     result_o,
    output logic                        replacerEnable_o,
    output logic [PageW-1:0]            replacerMissPage_o,
    output logic [AccessW-1:0]          replacerMissAccessType_o,
    input  logic                        replacerDone_i,
`ifdef TLB_FLUSH_EN
    input  logic                        flush_i,
`endif
    input  logic                        tlbWriteEnable_i,
    input  logic [PageW-1:0]            tlbWriteKey_i,
    input  logic [PageW+FlagsW+1:0]     tlbWriteValue_i
);

    localparam int EntryW = PageW + FlagsW + 2;
    localparam int IdxW   = (EntryCount > 1) ? $clog2(EntryCount) : 1;

    localparam logic [0:0] StateDefault = 1'b0;
    localparam logic [0:0] StateMiss    = 1'b1;

    localparam logic [AccessW-1:0] AccessInstruction = '0;

    logic [0:0]         state_q, state_d;
    logic [EntryCount-1:0] valid_q, valid_d;
    logic [PageW-1:0]   key_q   [EntryCount];
    logic [EntryW-1:0]  value_q [EntryCount];
    logic [IdxW-1:0]    replace_idx_q, replace_idx_d;
    logic [PageW-1:0]   miss_page_q, miss_page_d;
    logic [AccessW-1:0] miss_type_q, miss_type_d;

    logic               lookup_hit;
    logic [EntryW-1:0]  lookup_entry;
    logic               write_hit;
    logic [IdxW-1:0]    write_hit_idx;
    logic               write_en;
    logic [IdxW-1:0]    write_tgt;
    logic               flush_w;
    logic               drop_refill;

`ifdef TLB_FLUSH_EN
    logic discard_q, discard_d;

    assign flush_w     = flush_i;
    assign drop_refill = (state_q == StateMiss) && discard_q;

    // A flush during a walk poisons the refill; the poison lives only as long as the walk.
    always_comb begin
        discard_d = 1'b0;
        if (state_q == StateMiss && !replacerDone_i) begin
            discard_d = discard_q | flush_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            discard_q <= 1'b0;
        end else begin
            discard_q <= discard_d;
        end
    end
`else
    assign flush_w     = 1'b0;
    assign drop_refill = 1'b0;
`endif

    // Keys are unique among valid entries, so OR-combining the hit values yields the single match.
    always_comb begin
        lookup_hit    = 1'b0;
        lookup_entry  = '0;
        write_hit     = 1'b0;
        write_hit_idx = '0;
        for (int i = 0; i < EntryCount; i++) begin
            if (valid_q[i] && key_q[i] == requestPage_i) begin
                lookup_hit   = 1'b1;
                lookup_entry = lookup_entry | value_q[i];
            end
            if (valid_q[i] && key_q[i] == tlbWriteKey_i) begin
                write_hit     = 1'b1;
                write_hit_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_page_d = miss_page_q;
        miss_type_d = miss_type_q;
        done_o      = 1'b0;
        result_o    = '0;
        case (state_q)
            StateDefault: begin
                if (requestValid_i) begin
                    if (lookup_hit && !flush_w) begin
                        done_o   = 1'b1;
                        result_o = lookup_entry;
                    end else begin
                        state_d     = StateMiss;
                        miss_page_d = requestPage_i;
                        miss_type_d = requestAccessType_i;
                    end
                end
            end
            StateMiss: begin
                if (replacerDone_i) begin
                    state_d = StateDefault;
                end
            end
            default: state_d = StateDefault;
        endcase
    end

    // Installs overwrite an existing copy of the key; otherwise round-robin into the next slot.
    always_comb begin
        valid_d       = flush_w ? '0 : valid_q;
        replace_idx_d = replace_idx_q;
        write_en      = tlbWriteEnable_i && !flush_w && !drop_refill;
        write_tgt     = write_hit ? write_hit_idx : replace_idx_q;
        if (write_en) begin
            valid_d[write_tgt] = 1'b1;
            if (!write_hit) begin
                replace_idx_d = (replace_idx_q == IdxW'(EntryCount - 1)) ? '0 : replace_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StateDefault;
            valid_q       <= '0;
            replace_idx_q <= '0;
            miss_page_q   <= '0;
            miss_type_q   <= AccessInstruction;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            replace_idx_q <= replace_idx_d;
            miss_page_q   <= miss_page_d;
            miss_type_q   <= miss_type_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_en) begin
            key_q[write_tgt]   <= tlbWriteKey_i;
            value_q[write_tgt] <= tlbWriteValue_i;
        end
    end

    assign replacerEnable_o         = (state_q == StateMiss);
    assign replacerMissPage_o       = miss_page_q;
    assign replacerMissAccessType_o = miss_type_q;

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Randomized and directed bench for tlb_lookup_unit against a slot-array TLB reference model.
module tb_tlb_lookup_unit;

    localparam int N  = 8;
    localparam int PW = 20;
    localparam int FW = 8;
    localparam int AW = 2;
    localparam int EW = PW + FW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          requestValid = 1'b0;
    logic [PW-1:0] requestPage = '0;
    logic [AW-1:0] requestAccessType = '0;
    logic          done;
    logic [EW-1:0] result;
    logic          replacerEnable;
    logic [PW-1:0] replacerMissPage;
    logic [AW-1:0] replacerMissAccessType;
    logic          replacerDone = 1'b0;
    logic          flush = 1'b0;
    logic          tlbWriteEnable = 1'b0;
    logic [PW-1:0] tlbWriteKey = '0;
    logic [EW-1:0] tlbWriteValue = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tlb_lookup_unit #(.EntryCount(N), .PageW(PW), .FlagsW(FW), .AccessW(AW)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .requestValid_i           (requestValid),
        .requestPage_i            (requestPage),
        .requestAccessType_i      (requestAccessType),
        .done_o                   (done),
        .result_o                 (result),
        .replacerEnable_o         (replacerEnable),
        .replacerMissPage_o       (replacerMissPage),
        .replacerMissAccessType_o (replacerMissAccessType),
        .replacerDone_i           (replacerDone),
`ifdef TLB_FLUSH_EN
        .flush_i                  (flush),
`endif
        .tlbWriteEnable_i         (tlbWriteEnable),
        .tlbWriteKey_i            (tlbWriteKey),
        .tlbWriteValue_i          (tlbWriteValue)
    );

    // Reference model: N slots plus a round-robin pointer.
    bit            m_valid [N];
    logic [PW-1:0] m_key   [N];
    logic [EW-1:0] m_val   [N];
    int            m_ptr;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic bit m_lookup(input logic [PW-1:0] p, output logic [EW-1:0] v);
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_key[i] == p) begin
                v = m_val[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void m_install(input logic [PW-1:0] p, input logic [EW-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_key[i] == p) begin
                m_val[i] = v;
                return;
            end
        end
        m_valid[m_ptr] = 1'b1;
        m_key[m_ptr]   = p;
        m_val[m_ptr]   = v;
        m_ptr          = (m_ptr + 1) % N;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_reset();
    endtask

    // Full request: hit in one cycle, or miss + walk of `lat` extra cycles + refill + done.
    task automatic translate(input logic [PW-1:0] p, input logic [AW-1:0] t, input logic fault,
                             input logic [PW-1:0] ppn, input int lat);
        logic [EW-1:0] ev;
        logic [EW-1:0] wv;
        bit            hit;
        requestValid      = 1'b1;
        requestPage       = p;
        requestAccessType = t;
        hit = m_lookup(p, ev);
        @(negedge clk);
        if (hit) begin
            chk("hit_done", done, 1);
            chk("hit_result", result, ev);
            chk("hit_no_walk", replacerEnable, 0);
            step();
            requestValid = 1'b0;
            return;
        end
        chk("miss_done", done, 0);
        chk("miss_result", result, 0);
        step();
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("walk_en", replacerEnable, 1);
            chk("walk_page", replacerMissPage, p);
            chk("walk_type", replacerMissAccessType, t);
            chk("walk_done", done, 0);
            step();
        end
        wv = {1'b1, fault, ppn, FW'($urandom)};
        replacerDone   = 1'b1;
        tlbWriteEnable = 1'b1;
        tlbWriteKey    = p;
        tlbWriteValue  = wv;
        @(negedge clk);
        chk("walk_last_en", replacerEnable, 1);
        chk("walk_last_page", replacerMissPage, p);
        chk("walk_last_done", done, 0);
        step();
        replacerDone   = 1'b0;
        tlbWriteEnable = 1'b0;
        m_install(p, wv);
        @(negedge clk);
        chk("refill_done", done, 1);
        chk("refill_result", result, wv);
        chk("refill_en", replacerEnable, 0);
        step();
        requestValid = 1'b0;
    endtask

    initial begin
        logic [EW-1:0] sv;
        m_reset();
        do_reset();
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_en", replacerEnable, 0);
        step();

        // First translation: page 0x12345 walks and returns pageNumber 0x0ABCD.
        translate(20'h12345, 2'd1, 1'b0, 20'h0ABCD, 2);
        translate(20'h12345, 2'd1, 1'b0, 20'h0, 0);

        // Nine distinct pages into eight slots: page 1 is evicted, pages 2..9 remain.
        do_reset();
        for (int i = 1; i <= 9; i++) translate(PW'(i), 2'd0, 1'b0, PW'($urandom), $urandom_range(0, 3));
        for (int i = 2; i <= 9; i++) translate(PW'(i), 2'd0, 1'b0, 20'h0, 0);
        translate(20'h1, 2'd2, 1'b0, PW'($urandom), 1);

        // Fault entries are cached and hit again without a walk.
        translate(20'h7, 2'd1, 1'b1, PW'($urandom), 1);
        translate(20'h7, 2'd1, 1'b0, 20'h0, 0);

        // Spurious install of a resident key updates it in place.
        sv = {1'b1, 1'b0, 20'hFACE1, 8'h5A};
        tlbWriteEnable = 1'b1;
        tlbWriteKey    = 20'h1;
        tlbWriteValue  = sv;
        @(negedge clk);
        chk("spur_done", done, 0);
        chk("spur_en", replacerEnable, 0);
        step();
        tlbWriteEnable = 1'b0;
        m_install(20'h1, sv);
        translate(20'h1, 2'd0, 1'b0, 20'h0, 0);
        translate(20'h300, 2'd0, 1'b0, PW'($urandom), 0);
        for (int i = 2; i <= 9; i++) translate(PW'(i), 2'd0, 1'b0, PW'($urandom), 1);

        // Randomized traffic over a pool larger than the TLB.
        for (int n = 0; n < 60; n++) begin
            translate(PW'(20'h100 + $urandom_range(0, 11)), AW'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), PW'($urandom), $urandom_range(0, 3));
        end

`ifdef TLB_FLUSH_EN
        // Flush during the walk of 0x42 drops the refill and forces a second walk.
        do_reset();
        requestValid      = 1'b1;
        requestPage       = 20'h42;
        requestAccessType = 2'd1;
        step();
        @(negedge clk);
        chk("fl_walk1_en", replacerEnable, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_flush();
        sv = {1'b1, 1'b0, 20'h11111, 8'h01};
        replacerDone   = 1'b1;
        tlbWriteEnable = 1'b1;
        tlbWriteKey    = 20'h42;
        tlbWriteValue  = sv;
        step();
        replacerDone   = 1'b0;
        tlbWriteEnable = 1'b0;
        @(negedge clk);
        chk("fl_relookup_done", done, 0);
        step();
        @(negedge clk);
        chk("fl_walk2_en", replacerEnable, 1);
        chk("fl_walk2_page", replacerMissPage, 20'h42);
        sv = {1'b1, 1'b0, 20'h22222, 8'h02};
        replacerDone   = 1'b1;
        tlbWriteEnable = 1'b1;
        tlbWriteValue  = sv;
        step();
        replacerDone   = 1'b0;
        tlbWriteEnable = 1'b0;
        m_install(20'h42, sv);
        @(negedge clk);
        chk("fl_done", done, 1);
        chk("fl_result", result, sv);
        step();
        requestValid = 1'b0;
`endif

        // Reset in the middle of a walk abandons it and empties the TLB.
        translate(20'h500, 2'd0, 1'b0, PW'($urandom), 0);
        requestValid      = 1'b1;
        requestPage       = 20'h555;
        requestAccessType = 2'd2;
        step();
        @(negedge clk);
        chk("mid_walk_en", replacerEnable, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        requestValid = 1'b0;
        m_reset();
        @(negedge clk);
        chk("mid_rst_en", replacerEnable, 0);
        chk("mid_rst_done", done, 0);
        step();
        translate(20'h500, 2'd0, 1'b0, PW'($urandom), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
